// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD result display: segment patterns,
// controller states and the per-digit 9's complement helper.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    // Wraps for digits above 9; callers flag those as errors separately.
    function automatic logic [3:0] nines_comp(input logic [3:0] digit);
        return 4'd9 - digit;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Non-decimal codes show a dash.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0: seg_o = 7'b1000000;
            4'd1: seg_o = 7'b1111001;
            4'd2: seg_o = 7'b0100100;
            4'd3: seg_o = 7'b0110000;
            4'd4: seg_o = 7'b0011001;
            4'd5: seg_o = 7'b0010010;
            4'd6: seg_o = 7'b0000010;
            4'd7: seg_o = 7'b1111000;
            4'd8: seg_o = 7'b0000000;
            4'd9: seg_o = 7'b0010000;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_result_display.sv
// Captures a 10's-complement BCD adder result, converts it to sign-magnitude
// one digit per cycle, and scans it onto a 4-digit multiplexed display.
module bcd_result_display
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] D,
    input  logic        carryout,
    input  logic        add_sub,
    output logic        busy,
    output logic [15:0] mag,
    output logic        neg,
    output logic        ovf,
    output logic        err,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] d_q, d_d;
    logic [15:0] acc_q, acc_d;
    logic        comp_q, comp_d;
    logic        ovf_cand_q, ovf_cand_d;
    logic [1:0]  k_q, k_d;
    logic        c_q, c_d;
    logic        err_acc_q, err_acc_d;
    logic [15:0] mag_q, mag_d;
    logic        neg_q, neg_d, ovf_q, ovf_d, err_q, err_d;
    logic [PW-1:0] presc_q;
    logic [1:0]  idx_q;

    logic [3:0]  cur_digit, out_digit;
    logic [4:0]  t;
    logic        c_next, digit_bad, err_any;
    logic [15:0] acc_next;

    always_comb begin
        cur_digit = d_q[k_q*4 +: 4];
        digit_bad = (cur_digit > 4'd9);
        t         = {1'b0, nines_comp(cur_digit)} + {4'd0, c_q};
        out_digit = cur_digit;
        c_next    = c_q;
        if (comp_q) begin
            if (t == 5'd10) begin
                out_digit = 4'd0;
                c_next    = 1'b1;
            end else begin
                out_digit = t[3:0];
                c_next    = 1'b0;
            end
        end
        acc_next = acc_q;
        acc_next[k_q*4 +: 4] = out_digit;
        err_any  = err_acc_q | digit_bad;
    end

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        acc_d      = acc_q;
        comp_d     = comp_q;
        ovf_cand_d = ovf_cand_q;
        k_d        = k_q;
        c_d        = c_q;
        err_acc_d  = err_acc_q;
        mag_d      = mag_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        if (load) begin
            // Capture (or restart); displayed outputs stay as they are.
            state_d    = CONVERT;
            d_d        = D;
            acc_d      = '0;
            comp_d     = add_sub & ~carryout;
            ovf_cand_d = ~add_sub & carryout;
            k_d        = 2'd0;
            c_d        = 1'b1;
            err_acc_d  = 1'b0;
        end else if (state_q == CONVERT) begin
            acc_d     = acc_next;
            c_d       = c_next;
            err_acc_d = err_any;
            k_d       = k_q + 2'd1;
            if (k_q == 2'd3) begin
                state_d = IDLE;
                mag_d   = err_any ? 16'h0000 : acc_next;
                neg_d   = ~err_any & comp_q & (acc_next != 16'h0000);
                ovf_d   = ovf_cand_q;
                err_d   = err_any;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            d_q        <= '0;
            acc_q      <= '0;
            comp_q     <= 1'b0;
            ovf_cand_q <= 1'b0;
            k_q        <= 2'd0;
            c_q        <= 1'b1;
            err_acc_q  <= 1'b0;
            mag_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            acc_q      <= acc_d;
            comp_q     <= comp_d;
            ovf_cand_q <= ovf_cand_d;
            k_q        <= k_d;
            c_q        <= c_d;
            err_acc_q  <= err_acc_d;
            mag_q      <= mag_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    // Scan timing is free-running and independent of the converter.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    logic [6:0] dec_seg  [4];
    logic [6:0] disp_seg [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic blank;
        bcd_to_7seg u_dec (
            .digit_i (mag_q[gi*4 +: 4]),
            .seg_o   (dec_seg[gi])
        );
        if (gi == 0) begin : g_lsd
            assign blank = 1'b0;
        end else begin : g_upper
            assign blank = (mag_q[15:gi*4] == '0);
        end
        assign disp_seg[gi] = blank ? SEG_BLANK : dec_seg[gi];
    end

    assign an   = ~(4'b0001 << idx_q);
    assign seg  = err_q ? SEG_DASH : disp_seg[idx_q];
    assign busy = (state_q == CONVERT);
    assign mag  = mag_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
    assign err  = err_q;

endmodule
